// File: rtl/my_def.sv
// Shared sizing constants for the register-file datapath.
package my_def;
    localparam int DATA_W    = 16;
    localparam int REG_DEPTH = 16;
    localparam int ADR_W     = $clog2(REG_DEPTH);
endpackage

// File: rtl/my_struct.sv
// Shared pipeline interface structs between decode, register file and ALU.
package my_struct;
    import my_def::*;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic              ena;
        logic [ADR_W-1:0]  adr;
    } signal_alu_wr_reg;

    typedef struct packed {
        logic bolshe;
        logic menshe;
        logic ravno;
        logic ena;
        logic rav_adr;
        logic ena_ra;
    } signal_flag_wr_alu;

    typedef struct packed {
        logic bolshe;
        logic menshe;
        logic ravno;
        logic rav_adr;
    } signal_flag_alu;

    typedef struct packed {
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] b;
    } signal_data;
endpackage

// File: rtl/reg_file_16x16.sv
// Architectural register storage: one synchronous write port, two combinational read ports.
module reg_file_16x16
    import my_def::*;
(
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              we,
    input  logic [ADR_W-1:0]  wr_adr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [ADR_W-1:0]  rd_adr_a,
    input  logic [ADR_W-1:0]  rd_adr_b,
    output logic [DATA_W-1:0] rd_data_a,
    output logic [DATA_W-1:0] rd_data_b
);
    logic [DATA_W-1:0] mem [REG_DEPTH];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < REG_DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (we) begin
            mem[wr_adr] <= wr_data;
        end
    end

    assign rd_data_a = mem[rd_adr_a];
    assign rd_data_b = mem[rd_adr_b];
endmodule

// File: rtl/reg_wb.sv
// Register file with one-entry writeback buffer, operand forwarding, ALU flags and commit counter.
module reg_wb
    import my_def::*;
    import my_struct::*;
(
    input  logic              clk_i,
    input  logic              rst_i,
    input  signal_alu_wr_reg  alu_wr_reg_i,
    input  signal_flag_wr_alu flag_wr_i,
    input  logic              rd_en_i,
    input  logic [ADR_W-1:0]  rd_adr_a_i,
    input  logic [ADR_W-1:0]  rd_adr_b_i,
    output signal_data        data_o,
    output signal_flag_alu    flag_o,
    output logic [15:0]       wr_cnt_o
);
    typedef struct packed {
        logic              vld;
        logic [ADR_W-1:0]  adr;
        logic [DATA_W-1:0] data;
    } wb_t;

    wb_t               wb_q;
    logic [DATA_W-1:0] rf_a;
    logic [DATA_W-1:0] rf_b;

    // Newest value wins: the write arriving this cycle, then the buffered one, then storage.
    function automatic logic [DATA_W-1:0] fwd(
        input logic [ADR_W-1:0]  adr,
        input signal_alu_wr_reg  wr,
        input wb_t               wb,
        input logic [DATA_W-1:0] rf_val
    );
        if (wr.ena && wr.adr == adr)      return wr.data;
        else if (wb.vld && wb.adr == adr) return wb.data;
        else                              return rf_val;
    endfunction

    reg_file_16x16 u_rf (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .we        (wb_q.vld),
        .wr_adr    (wb_q.adr),
        .wr_data   (wb_q.data),
        .rd_adr_a  (rd_adr_a_i),
        .rd_adr_b  (rd_adr_b_i),
        .rd_data_a (rf_a),
        .rd_data_b (rf_b)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wb_q.vld <= 1'b0;
            data_o   <= '0;
            flag_o   <= '0;
            wr_cnt_o <= '0;
        end else begin
            wb_q.vld <= alu_wr_reg_i.ena;
            if (alu_wr_reg_i.ena) begin
                wb_q.adr  <= alu_wr_reg_i.adr;
                wb_q.data <= alu_wr_reg_i.data;
            end
            if (wb_q.vld) begin
                wr_cnt_o <= wr_cnt_o + 16'd1;
            end
            if (rd_en_i) begin
                data_o.a <= fwd(rd_adr_a_i, alu_wr_reg_i, wb_q, rf_a);
                data_o.b <= fwd(rd_adr_b_i, alu_wr_reg_i, wb_q, rf_b);
            end
            // Comparison flags and the address flag have independent enables.
            if (flag_wr_i.ena) begin
                flag_o.bolshe <= flag_wr_i.bolshe;
                flag_o.menshe <= flag_wr_i.menshe;
                flag_o.ravno  <= flag_wr_i.ravno;
            end
            if (flag_wr_i.ena_ra) begin
                flag_o.rav_adr <= flag_wr_i.rav_adr;
            end
        end
    end
endmodule

// File: tb/tb_reg_wb.sv
// Randomized scoreboard bench for reg_wb against an architectural (latest-value) model.
module tb_reg_wb;
    import my_def::*;
    import my_struct::*;

    logic              clk_i = 1'b0;
    logic              rst_i = 1'b1;
    signal_alu_wr_reg  alu_wr_reg_i = '0;
    signal_flag_wr_alu flag_wr_i = '0;
    logic              rd_en_i = 1'b0;
    logic [3:0]        rd_adr_a_i = '0;
    logic [3:0]        rd_adr_b_i = '0;
    signal_data        data_o;
    signal_flag_alu    flag_o;
    logic [15:0]       wr_cnt_o;

    reg_wb dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .alu_wr_reg_i (alu_wr_reg_i),
        .flag_wr_i    (flag_wr_i),
        .rd_en_i      (rd_en_i),
        .rd_adr_a_i   (rd_adr_a_i),
        .rd_adr_b_i   (rd_adr_b_i),
        .data_o       (data_o),
        .flag_o       (flag_o),
        .wr_cnt_o     (wr_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    endtask

    // Reference model: a register holds the newest value written to it from the moment
    // the write is presented; each write is counted one edge after it is accepted
    // unless a reset intervenes.
    logic [15:0]    arch [16];
    int             edge_n = 0;
    int             pend_q[$];
    logic [15:0]    m_cnt = '0;
    signal_flag_alu m_flag = '0;
    signal_data     exp_q[$];
    bit             out_evt = 0;

    always @(posedge clk_i) begin
        signal_data e;
        edge_n++;
        out_evt = 0;
        if (rst_i) begin
            foreach (arch[i]) arch[i] = '0;
            pend_q.delete();
            m_cnt   = '0;
            m_flag  = '0;
            exp_q.push_back('0);
            out_evt = 1;
        end else begin
            while (pend_q.size() > 0 && pend_q[0] <= edge_n - 1) begin
                void'(pend_q.pop_front());
                m_cnt = m_cnt + 16'd1;
            end
            if (alu_wr_reg_i.ena) begin
                arch[alu_wr_reg_i.adr] = alu_wr_reg_i.data;
                pend_q.push_back(edge_n);
            end
            if (rd_en_i) begin
                e.a = arch[rd_adr_a_i];
                e.b = arch[rd_adr_b_i];
                exp_q.push_back(e);
                out_evt = 1;
            end
            if (flag_wr_i.ena) begin
                m_flag.bolshe = flag_wr_i.bolshe;
                m_flag.menshe = flag_wr_i.menshe;
                m_flag.ravno  = flag_wr_i.ravno;
            end
            if (flag_wr_i.ena_ra) m_flag.rav_adr = flag_wr_i.rav_adr;
        end
    end

    // Monitor: checks every cycle, pops the scoreboard when a read or reset result is due.
    signal_data last_data = '0;
    always @(negedge clk_i) begin
        signal_data e;
        if (edge_n > 0) begin
            chk("flags", 32'(flag_o), 32'(m_flag));
            chk("wr_cnt", 32'(wr_cnt_o), 32'(m_cnt));
            if (out_evt) begin
                if (exp_q.size() == 0) begin
                    chk("sb_underflow", 32'(exp_q.size()), 32'd1);
                end else begin
                    e = exp_q.pop_front();
                    chk("data", data_o, e);
                    last_data = e;
                end
            end else begin
                chk("data_hold", data_o, last_data);
            end
        end
    end

    task automatic cyc(input bit r, input bit we, input logic [3:0] wa, input logic [15:0] wd,
                       input bit re, input logic [3:0] ra, input logic [3:0] rb,
                       input signal_flag_wr_alu f);
        rst_i             = r;
        alu_wr_reg_i.ena  = we;
        alu_wr_reg_i.adr  = wa;
        alu_wr_reg_i.data = wd;
        rd_en_i           = re;
        rd_adr_a_i        = ra;
        rd_adr_b_i        = rb;
        flag_wr_i         = f;
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle();
        cyc(0, 0, 4'h0, 16'h0, 0, 4'h0, 4'h0, '0);
    endtask

    initial begin
        signal_flag_wr_alu f0, f1, f2, fr;
        logic [3:0] wa;
        f0 = '0;
        f1 = '{bolshe: 1'b1, menshe: 1'b0, ravno: 1'b0, ena: 1'b1, rav_adr: 1'b1, ena_ra: 1'b0};
        f2 = '{bolshe: 1'b0, menshe: 1'b0, ravno: 1'b0, ena: 1'b0, rav_adr: 1'b1, ena_ra: 1'b1};

        cyc(1, 0, 4'h0, 16'h0, 0, 4'h0, 4'h0, f0);
        cyc(1, 1, 4'h1, 16'h5555, 1, 4'h1, 4'h1, f1);
        // Reset state read
        cyc(0, 0, 4'h0, 16'h0, 1, 4'h3, 4'h7, f0);
        chk("rst_data", data_o, 32'h0);
        chk("rst_cnt", 32'(wr_cnt_o), 32'h0);
        // Same-cycle write forwarding
        cyc(0, 1, 4'h5, 16'h1234, 1, 4'h5, 4'h0, f0);
        chk("fwd_a", 32'(data_o.a), 32'h1234);
        idle();
        chk("cnt_one", 32'(wr_cnt_o), 32'h1);
        // Back-to-back writes to one address
        cyc(0, 1, 4'h2, 16'h00AA, 0, 4'h0, 4'h0, f0);
        cyc(0, 1, 4'h2, 16'h00BB, 1, 4'h2, 4'h2, f0);
        chk("b2b", data_o, 32'h00BB_00BB);
        idle();
        idle();
        cyc(0, 0, 4'h0, 16'h0, 1, 4'h2, 4'h2, f0);
        chk("b2b_commit", data_o, 32'h00BB_00BB);
        // Independent flag enables
        cyc(0, 0, 4'h0, 16'h0, 0, 4'h0, 4'h0, f1);
        chk("flag1", 32'(flag_o), 32'b1000);
        cyc(0, 0, 4'h0, 16'h0, 0, 4'h0, 4'h0, f2);
        chk("flag2", 32'(flag_o), 32'b1001);
        // Reset discards a pending writeback
        cyc(0, 1, 4'h9, 16'hBEEF, 0, 4'h0, 4'h0, f0);
        cyc(1, 0, 4'h0, 16'h0, 0, 4'h0, 4'h0, f0);
        cyc(0, 0, 4'h0, 16'h0, 1, 4'h9, 4'h9, f0);
        chk("rst_discard", data_o, 32'h0);
        chk("rst_discard_cnt", 32'(wr_cnt_o), 32'h0);

        for (int i = 0; i < 600; i++) begin
            fr = 6'($urandom());
            wa = ($urandom_range(0, 1) == 0) ? 4'($urandom_range(0, 3)) : 4'($urandom_range(0, 15));
            cyc($urandom_range(0, 49) == 0, 1'($urandom()), wa, 16'($urandom()),
                1'($urandom()), 4'($urandom_range(0, 3)), 4'($urandom_range(0, 15)), fr);
        end

        // Counter wrap: 65535 commits to reach FFFF, then one more
        cyc(1, 0, 4'h0, 16'h0, 0, 4'h0, 4'h0, f0);
        for (int i = 0; i < 65535; i++) begin
            cyc(0, 1, 4'(i), 16'(i), (i % 97) == 0, 4'(i), 4'(i + 3), f0);
        end
        idle();
        chk("cnt_ffff", 32'(wr_cnt_o), 32'hFFFF);
        cyc(0, 1, 4'hE, 16'hCAFE, 0, 4'h0, 4'h0, f0);
        idle();
        chk("cnt_wrap", 32'(wr_cnt_o), 32'h0);
        cyc(0, 0, 4'h0, 16'h0, 1, 4'hE, 4'h2, f0);
        idle();

        chk("sb_drain", 32'(exp_q.size()), 32'h0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/reg_wb.md
REG_WB -- requirements
Module: reg_wb

Interface
REQ-001 The module SHALL have a single clock and a reset that is synchronous and active-high: clk_i  input  1  rising-edge clock for all state.
REQ-002 rst_i  input  1  synchronous active-high reset, sampled on rising clk_i edge.
REQ-003 alu_wr_reg_i  input  signal_alu_wr_reg (data[15:0], ena, adr[3:0])  register write request from the ALU stage.
REQ-004 flag_wr_i  input  signal_flag_wr_alu (bolshe, menshe, ravno, ena, rav_adr, ena_ra)  flag write request from the ALU stage.
REQ-005 rd_en_i  input  1  operand read strobe from the decode stage.
REQ-006 rd_adr_a_i, rd_adr_b_i  input  4 each  operand register addresses for a and b.
REQ-007 data_o  output  signal_data (a[15:0], b[15:0])  registered operands to the ALU data input.
REQ-008 flag_o  output  signal_flag_alu (bolshe, menshe, ravno, rav_adr)  registered flags to the ALU flag input.
REQ-009 wr_cnt_o  output  16  count of register commits.

Function
REQ-010 The register file SHALL hold 16 entries x 16 bits; all entries, including 0, are writable.
REQ-011 On an edge with alu_wr_reg_i.ena=1, {adr,data} SHALL be captured into a one-entry writeback register wb_q, marked valid; with ena=0, wb_q valid SHALL clear.
REQ-012 A valid wb_q SHALL commit to regfile[wb_q.adr] on the next edge; write-to-architectural-state latency is 2 edges.
REQ-013 Each commit SHALL increment wr_cnt_o by 1, wrapping 16'hFFFF -> 16'h0000.
REQ-014 On an edge with rd_en_i=1, data_o.a and data_o.b SHALL load the operand values for rd_adr_a_i and rd_adr_b_i; data_o is valid the cycle after rd_en_i.
REQ-015 With rd_en_i=0, data_o SHALL hold its previous value.
REQ-016 Operand forwarding priority SHALL be: same-cycle alu_wr_reg_i (ena=1, adr match) > valid wb_q (adr match) > regfile; a read never returns stale data.
REQ-017 rd_adr_a_i == rd_adr_b_i SHALL return the same value on both operands.
REQ-018 Back-to-back writes to the same address SHALL commit in order; the later write wins.
REQ-019 On an edge with flag_wr_i.ena=1, flag_o.bolshe/menshe/ravno SHALL load the three input bits as given; with ena=0 they hold.
REQ-020 On an edge with flag_wr_i.ena_ra=1, flag_o.rav_adr SHALL load flag_wr_i.rav_adr; with ena_ra=0 it holds; ena and ena_ra act independently in the same cycle.
REQ-021 Flag update latency SHALL be 1 edge; flags are not forwarded combinationally.

Reset
REQ-022 On an edge with rst_i=1, all regfile entries, data_o, flag_o, and wr_cnt_o SHALL become 0, and wb_q valid SHALL clear.
REQ-023 Reset SHALL override every same-cycle write, flag write, and read; a pending wb_q is discarded, not committed, and is not counted.
REQ-024 The first edge after rst_i deasserts SHALL behave as normal operation.

Structure
REQ-025 signal_alu_wr_reg, signal_flag_wr_alu, signal_flag_alu, and signal_data SHALL come unchanged from the shared struct package (my_struct); regfile depth and data width SHALL be shared constants in my_def.
REQ-026 The storage array plus its write port SHALL be a sub-module named reg_file_16x16 (one synchronous write port, two combinational read ports); forwarding, wb_q, flags, and the counter SHALL stay in reg_wb.

Verification
REQ-027 Reset, then set rd_en_i=1, adr a=3, adr b=7 -> the next cycle shows data_o={0,0}, flag_o=0, and wr_cnt_o=0.
REQ-028 Write adr=5 data=16'h1234; in the same cycle set rd_en_i=1 with a=5 -> the next cycle shows data_o.a=16'h1234; two cycles later wr_cnt_o=1.
REQ-029 Write adr=2 data=16'h00AA, then adr=2 data=16'h00BB on consecutive cycles; read a=b=2 on the second cycle -> both operands are 16'h00BB, and regfile[2] is 16'h00BB after the commits.
REQ-030 flag_wr_i={bolshe=1, ena=1, rav_adr=1, ena_ra=0} -> flag_o.bolshe=1, rav_adr=0; then ena=0, ena_ra=1, rav_adr=1 -> bolshe stays 1 and rav_adr=1.
REQ-031 Write adr=9 data=16'hBEEF, and assert rst_i on the next cycle, while wb_q is pending -> after reset, a read of 9 returns 0 and wr_cnt_o=0.
REQ-032 Preload wr_cnt_o to 16'hFFFF through 65535 commits, then issue one more write -> wr_cnt_o=16'h0000.
